lsu_axi_bridge: RTL

Data-side memory bridge directly downstream of the load/store unit. Accepts one load or store request at a time (address, size, byte strobes, store data), runs a single AXI4-Lite-style read or write transaction on the data bus, and returns load data or store completion with an error flag. The LSU holds its request until the bridge signals completion.

---
 rtl/lsu_axi_bridge_pkg.sv | 22 ++
 rtl/lsu_axi_bridge.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/lsu_axi_bridge_pkg.sv
// rtl/lsu_axi_bridge_pkg.sv - shared types and codes for the LSU data-side AXI bridge
package lsu_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR,
    ST_WR_RESP,
    ST_DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [2:0] SIZE_1B = 3'd0;
  localparam logic [2:0] SIZE_2B = 3'd1;
  localparam logic [2:0] SIZE_4B = 3'd2;
  localparam logic [2:0] SIZE_8B = 3'd3;

endpackage

// File: rtl/lsu_axi_bridge.sv
// rtl/lsu_axi_bridge.sv - single-outstanding LSU to AXI4-Lite data bridge with response watchdog
module lsu_axi_bridge
  import lsu_axi_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2:0]          req_size,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                req_ready,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int              WD_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  state_t          state, state_next;
  logic [WD_W-1:0] wd_cnt;
  logic            aw_done, w_done;
  logic            accept, aw_fin, w_fin, timeout_hit;

  assign req_ready   = (state == ST_IDLE);
  assign accept      = req_valid && req_ready;
  assign aw_fin      = aw_done || (awvalid && awready);
  assign w_fin       = w_done || (wvalid && wready);
  // Fires in the last waiting cycle so DONE lands exactly TIMEOUT cycles after entry.
  assign timeout_hit = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (req_valid) state_next = req_we ? ST_WR : ST_RD_ADDR;
      ST_RD_ADDR: if (arready) state_next = ST_RD_DATA;
      ST_RD_DATA: if (rvalid || timeout_hit) state_next = ST_DONE;
      ST_WR:      if (aw_fin && w_fin) state_next = ST_WR_RESP;
      ST_WR_RESP: if (bvalid || timeout_hit) state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt     <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      araddr     <= '0;
      arsize     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= '0;
      awsize     <= '0;
      awvalid    <= 1'b0;
      wdata      <= '0;
      wstrb      <= '0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (state == ST_RD_DATA || state == ST_WR_RESP) wd_cnt <= wd_cnt + 1'b1;
      else                                            wd_cnt <= '0;

      if (accept) begin
        resp_err <= 1'b0;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
        if (req_we) begin
          awaddr <= req_addr;
          awsize <= req_size;
          wdata  <= req_wdata;
          wstrb  <= req_wstrb;
        end else begin
          araddr <= req_addr;
          arsize <= req_size;
        end
      end

      // Write address and data channels retire independently.
      if (accept && req_we)       awvalid <= 1'b1;
      else if (awvalid && awready) begin
        awvalid <= 1'b0;
        aw_done <= 1'b1;
      end
      if (accept && req_we)     wvalid <= 1'b1;
      else if (wvalid && wready) begin
        wvalid <= 1'b0;
        w_done <= 1'b1;
      end

      arvalid    <= (state_next == ST_RD_ADDR);
      rready     <= (state_next == ST_RD_DATA);
      bready     <= (state_next == ST_WR_RESP);
      resp_valid <= (state_next == ST_DONE);

      if (state == ST_RD_DATA) begin
        if (rvalid) begin
          resp_rdata <= rdata;
          resp_err   <= (rresp != RESP_OKAY);
        end else if (timeout_hit) begin
          resp_rdata <= '0;
          resp_err   <= 1'b1;
        end
      end
      if (state == ST_WR_RESP) begin
        if (bvalid)           resp_err <= (bresp != RESP_OKAY);
        else if (timeout_hit) resp_err <= 1'b1;
      end
    end
  end

endmodule
